beat_sequencer: RTL and testbench

//   Multi-track beat position generator for the audio/note engine.
//   Per-track lengths, runtime tempo divider, per-track loop or one-shot.

---
 rtl/beat_pkg.sv | 42 ++++
 rtl/beat_prescaler.sv | 44 ++++
 rtl/beat_sequencer.sv | 151 +++++++++++++++
 tb/tb_beat_sequencer.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/beat_pkg.sv
// Shared constants for the beat sequencer: state encoding, track indices,
// default geometry and a helper that extracts one track length from a packed vector.
package beat_pkg;

  localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
  localparam logic [1:0] ST_PLAY_ENC  = 2'd1;
  localparam logic [1:0] ST_PAUSE_ENC = 2'd2;
  localparam logic [1:0] ST_DONE_ENC  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = ST_IDLE_ENC,
    ST_PLAY  = ST_PLAY_ENC,
    ST_PAUSE = ST_PAUSE_ENC,
    ST_DONE  = ST_DONE_ENC
  } state_e;

  localparam int TRK_START   = 0;
  localparam int TRK_EASY    = 1;
  localparam int TRK_NORMAL  = 2;
  localparam int TRK_HARD    = 3;
  localparam int TRK_INFERNO = 4;
  localparam int TRK_FAIL    = 5;

  localparam int P_NUM_TRACKS = 6;
  localparam int P_TRK_W      = 3;
  localparam int P_BEAT_W     = 12;
  localparam int P_DIV_W      = 24;

  localparam logic [P_NUM_TRACKS*P_BEAT_W-1:0] P_TRACK_LEN =
    {12'd128, 12'd512, 12'd512, 12'd512, 12'd512, 12'd256};
  localparam logic [P_NUM_TRACKS-1:0] P_LOOP_MASK = 6'b011111;

  // Upper bound on the packed length vector the helper accepts.
  localparam int LEN_VEC_MAX = 256;

  function automatic logic [31:0] track_len(input logic [LEN_VEC_MAX-1:0] lens,
                                            input int unsigned idx,
                                            input int unsigned bw);
    return 32'(lens >> (idx * bw)) & ((32'd1 << bw) - 32'd1);
  endfunction

endpackage

// File: rtl/beat_prescaler.sv
// Tempo divider: counts clk cycles while running and pulses adv once every
// tick_div+1 cycles; a shrinking tick_div never causes a long wrap-around stall.
module beat_prescaler #(
  parameter int DIV_W = 24
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             run,
  input  logic             clear,
  input  logic [DIV_W-1:0] tick_div,
  output logic             adv
);

  logic [DIV_W-1:0] div_cnt_q;
  logic [DIV_W-1:0] div_cnt_d;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves a latch.
    div_cnt_d = div_cnt_q;
    adv       = 1'b0;
    if (clear) begin
      div_cnt_d = '0;
    end else if (run) begin
      if (div_cnt_q == tick_div) begin
        div_cnt_d = '0;
        adv       = 1'b1;
      end else if (div_cnt_q > tick_div) begin
        div_cnt_d = '0;
      end else begin
        div_cnt_d = div_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous, so it lives inside the clocked branch; state uses <= only.
    if (!reset_n) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

endmodule

// File: rtl/beat_sequencer.sv
// Multi-track beat position generator with per-track length and loop/one-shot mode.
// Optional feature macro: BEAT_SEEK_EN adds seek_valid/seek_beat to jump within a track.
module beat_sequencer
  import beat_pkg::*;
#(
  parameter int                          NUM_TRACKS = P_NUM_TRACKS,
  parameter int                          TRK_W      = P_TRK_W,
  parameter int                          BEAT_W     = P_BEAT_W,
  parameter int                          DIV_W      = P_DIV_W,
  parameter logic [NUM_TRACKS*BEAT_W-1:0] TRACK_LEN  = P_TRACK_LEN,
  parameter logic [NUM_TRACKS-1:0]        LOOP_MASK  = P_LOOP_MASK
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic [TRK_W-1:0]  track_sel,
  input  logic              pause,
  input  logic [DIV_W-1:0]  tick_div,
`ifdef BEAT_SEEK_EN
  input  logic              seek_valid,
  input  logic [BEAT_W-1:0] seek_beat,
`endif
  output logic [BEAT_W-1:0] ibeat,
  output logic              beat_tick,
  output logic              wrap,
  output logic              done,
  output logic [1:0]        state
);

  localparam int unsigned NT = NUM_TRACKS;

  state_e            state_q, state_d;
  logic [BEAT_W-1:0] ibeat_q, ibeat_d;
  logic [TRK_W-1:0]  cur_track_q, cur_track_d;
  logic              beat_tick_q, beat_tick_d;
  logic              wrap_q, wrap_d;
  logic              done_q, done_d;

  logic [BEAT_W-1:0] len;
  logic [BEAT_W-1:0] last_beat;
  logic              loops;
  logic              trk_chg;
  logic              seek_fire;
  logic              run;
  logic              clear;
  logic              adv;

  assign len       = BEAT_W'(track_len(LEN_VEC_MAX'(TRACK_LEN), 32'(cur_track_q), BEAT_W));
  assign last_beat = len - 1'b1;
  assign loops     = LOOP_MASK[cur_track_q];
  assign trk_chg   = (32'(track_sel) < NT) && (track_sel != cur_track_q);

`ifdef BEAT_SEEK_EN
  assign seek_fire = seek_valid && (state_q != ST_IDLE);
`else
  assign seek_fire = 1'b0;
`endif

  // The divider only counts when nothing of higher priority owns this edge.
  assign run   = enable && !trk_chg && !seek_fire && !pause &&
                 ((state_q == ST_PLAY) || (state_q == ST_PAUSE));
  assign clear = !enable || trk_chg || seek_fire;

  beat_prescaler #(
    .DIV_W (DIV_W)
  ) u_prescaler (
    .clk      (clk),
    .reset_n  (reset_n),
    .run      (run),
    .clear    (clear),
    .tick_div (tick_div),
    .adv      (adv)
  );

  always_comb begin
    state_d     = state_q;
    ibeat_d     = ibeat_q;
    cur_track_d = cur_track_q;
    beat_tick_d = 1'b0;
    wrap_d      = 1'b0;

    if (!enable) begin
      state_d = ST_IDLE;
      ibeat_d = '0;
      if (trk_chg) cur_track_d = track_sel;
    end else if (trk_chg) begin
      cur_track_d = track_sel;
      ibeat_d     = '0;
      state_d     = ST_PLAY;
    end else if (seek_fire) begin
`ifdef BEAT_SEEK_EN
      ibeat_d = (seek_beat > last_beat) ? last_beat : seek_beat;
      if ((state_q == ST_DONE) && (seek_beat < last_beat)) state_d = ST_PLAY;
`endif
    end else begin
      unique case (state_q)
        ST_IDLE: state_d = ST_PLAY;
        ST_PLAY, ST_PAUSE: begin
          if (pause) begin
            state_d = ST_PAUSE;
          end else begin
            state_d = ST_PLAY;
            if (adv) begin
              if (ibeat_q == last_beat) begin
                if (loops) begin
                  ibeat_d     = '0;
                  wrap_d      = 1'b1;
                  beat_tick_d = 1'b1;
                end else begin
                  state_d = ST_DONE;
                end
              end else begin
                ibeat_d     = ibeat_q + 1'b1;
                beat_tick_d = 1'b1;
              end
            end
          end
        end
        ST_DONE: state_d = ST_DONE;
        default: state_d = ST_IDLE;
      endcase
    end

    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      ibeat_q     <= '0;
      cur_track_q <= '0;
      beat_tick_q <= 1'b0;
      wrap_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ibeat_q     <= ibeat_d;
      cur_track_q <= cur_track_d;
      beat_tick_q <= beat_tick_d;
      wrap_q      <= wrap_d;
      done_q      <= done_d;
    end
  end

  assign ibeat     = ibeat_q;
  assign beat_tick = beat_tick_q;
  assign wrap      = wrap_q;
  assign done      = done_q;
  assign state     = state_q;

endmodule

// File: tb/tb_beat_sequencer.sv
// Directed bench for beat_sequencer: expected outputs are queued as stimulus is
// applied and popped after each clock edge. Seek steps run only with BEAT_SEEK_EN.
module tb_beat_sequencer;
  import beat_pkg::*;

  localparam int BW = 12;
  localparam int DW = 24;
  localparam int TW = 3;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          enable;
  logic [TW-1:0] track_sel;
  logic          pause;
  logic [DW-1:0] tick_div;
`ifdef BEAT_SEEK_EN
  logic          seek_valid;
  logic [BW-1:0] seek_beat;
`endif
  logic [BW-1:0] ibeat;
  logic          beat_tick;
  logic          wrap;
  logic          done;
  logic [1:0]    state;

  always #5 clk = ~clk;

  beat_sequencer dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .track_sel  (track_sel),
    .pause      (pause),
    .tick_div   (tick_div),
`ifdef BEAT_SEEK_EN
    .seek_valid (seek_valid),
    .seek_beat  (seek_beat),
`endif
    .ibeat      (ibeat),
    .beat_tick  (beat_tick),
    .wrap       (wrap),
    .done       (done),
    .state      (state)
  );

  typedef struct {
    string         tag;
    logic [BW-1:0] ibeat;
    logic          tick;
    logic          wrap;
    logic          done;
    logic [1:0]    st;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   exp_beat = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input int b, input logic tk, input logic wr,
                      input logic dn, input logic [1:0] st);
    exp_t e;
    e.tag   = tag;
    e.ibeat = BW'(b);
    e.tick  = tk;
    e.wrap  = wr;
    e.done  = dn;
    e.st    = st;
    exp_q.push_back(e);
  endtask

  // One clock edge, then compare the DUT against the oldest queued expectation.
  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check({e.tag, ".ibeat"}, 32'(ibeat), 32'(e.ibeat));
    check({e.tag, ".tick"},  32'(beat_tick), 32'(e.tick));
    check({e.tag, ".wrap"},  32'(wrap), 32'(e.wrap));
    check({e.tag, ".done"},  32'(done), 32'(e.done));
    check({e.tag, ".state"}, 32'(state), 32'(e.st));
  endtask

  // Plays n beats from a divider count of 0, following the spec's beat rules.
  task automatic play_beats(input string tag, input int n, input int len,
                            input bit loops, input int div);
    for (int i = 0; i < n; i++) begin
      repeat (div) begin
        push(tag, exp_beat, 1'b0, 1'b0, 1'b0, ST_PLAY);
        step();
      end
      if (exp_beat == len - 1) begin
        if (loops) begin
          exp_beat = 0;
          push(tag, 0, 1'b1, 1'b1, 1'b0, ST_PLAY);
        end else begin
          push(tag, exp_beat, 1'b0, 1'b0, 1'b1, ST_DONE);
        end
      end else begin
        exp_beat++;
        push(tag, exp_beat, 1'b1, 1'b0, 1'b0, ST_PLAY);
      end
      step();
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    enable    = 1'b0;
    track_sel = '0;
    pause     = 1'b0;
    tick_div  = DW'(3);
`ifdef BEAT_SEEK_EN
    seek_valid = 1'b0;
    seek_beat  = '0;
`endif
    push("reset", 0, 1'b0, 1'b0, 1'b0, ST_IDLE);
    step();

    // Track 1 loops over 512 beats at one beat per 4 clocks.
    reset_n   = 1'b1;
    enable    = 1'b1;
    track_sel = 3'd1;
    push("t1_start", 0, 1'b0, 1'b0, 1'b0, ST_PLAY);
    step();
    exp_beat = 0;
    play_beats("t1_play", 512, 512, 1'b1, 3);
    play_beats("t1_run", 300, 512, 1'b1, 3);

    // Divider already past a shrunk tick_div resets instead of wrapping.
    repeat (2) begin
      push("div_pre", exp_beat, 1'b0, 1'b0, 1'b0, ST_PLAY);
      step();
    end
    tick_div = DW'(1);
    push("div_shrink_clr", exp_beat, 1'b0, 1'b0, 1'b0, ST_PLAY);
    step();
    play_beats("div_shrink", 1, 512, 1'b1, 1);
    tick_div = DW'(3);

    // Track change mid-play restarts at beat 0 with a fresh divider.
    track_sel = 3'd2;
    push("t3_chg", 0, 1'b0, 1'b0, 1'b0, ST_PLAY);
    step();
    exp_beat = 0;
    play_beats("t3_after", 10, 512, 1'b1, 3);

    // Pause at beat 10 with div_cnt=2; release resumes the partial interval.
    repeat (2) begin
      push("t4_pre", 10, 1'b0, 1'b0, 1'b0, ST_PLAY);
      step();
    end
    pause = 1'b1;
    repeat (20) begin
      push("t4_pause", 10, 1'b0, 1'b0, 1'b0, ST_PAUSE);
      step();
    end
    pause = 1'b0;
    push("t4_rel", 10, 1'b0, 1'b0, 1'b0, ST_PLAY);
    step();
    push("t4_tick", 11, 1'b1, 1'b0, 1'b0, ST_PLAY);
    step();
    exp_beat = 11;

    enable = 1'b0;
    push("disable", 0, 1'b0, 1'b0, 1'b0, ST_IDLE);
    step();
    enable = 1'b1;
    push("reenable", 0, 1'b0, 1'b0, 1'b0, ST_PLAY);
    step();
    exp_beat = 0;

    // Reset mid-play discards position and the track; an out-of-range select is ignored.
    play_beats("t5_run", 200, 512, 1'b1, 3);
    reset_n   = 1'b0;
    track_sel = 3'd7;
    push("t5_rst", 0, 1'b0, 1'b0, 1'b0, ST_IDLE);
    step();
    reset_n = 1'b1;
    push("t5_idle_play", 0, 1'b0, 1'b0, 1'b0, ST_PLAY);
    step();
    tick_div = '0;
    exp_beat = 0;
    play_beats("t5_trk0", 256, 256, 1'b1, 0);

    // One-shot failure track ends in DONE holding its last beat.
    track_sel = 3'd5;
    push("t2_chg", 0, 1'b0, 1'b0, 1'b0, ST_PLAY);
    step();
    exp_beat = 0;
    play_beats("t2_run", 127, 128, 1'b0, 0);
    play_beats("t2_end", 1, 128, 1'b0, 0);
    repeat (4) begin
      push("t2_hold", 127, 1'b0, 1'b0, 1'b1, ST_DONE);
      step();
    end
    pause = 1'b1;
    push("t2_pause_done", 127, 1'b0, 1'b0, 1'b1, ST_DONE);
    step();
    pause = 1'b0;

`ifdef BEAT_SEEK_EN
    seek_valid = 1'b1;
    seek_beat  = BW'(5);
    push("t6_done_seek", 5, 1'b0, 1'b0, 1'b0, ST_PLAY);
    step();
    seek_valid = 1'b0;
    exp_beat   = 5;
    play_beats("t6_resume", 2, 128, 1'b0, 0);
`endif

    track_sel = 3'd1;
    push("done_exit", 0, 1'b0, 1'b0, 1'b0, ST_PLAY);
    step();
    exp_beat = 0;
    tick_div = DW'(3);

`ifdef BEAT_SEEK_EN
    play_beats("t6_pre", 1, 512, 1'b1, 3);
    seek_valid = 1'b1;
    seek_beat  = BW'(600);
    push("t6_clamp", 511, 1'b0, 1'b0, 1'b0, ST_PLAY);
    step();
    seek_valid = 1'b0;
    exp_beat   = 511;
    play_beats("t6_wrap", 1, 512, 1'b1, 3);
`endif

    play_beats("final", 2, 512, 1'b1, 3);
    check("sb_drain", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
